// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared defaults and types for the data-memory arbiter.
//   MAX_WAIT_DEF : host wait cycles before the host wins a conflict.
//   DEPTH_DEF    : data-memory depth in 32-bit words.
//   owner_e      : which requester drives the memory port this cycle.
package dmem_arb_pkg;
  localparam int MAX_WAIT_DEF = 4;
  localparam int DEPTH_DEF    = 64;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the CPU, host and memory sides of the arbiter.
//   slave  : arbiter view (requests in, grants/memory port out).
//   master : environment view (CPU, host and memory model).
// Handshake: cpu_req/host_req are level requests sampled every cycle.
// host_gnt is a same-cycle combinational grant; the host holds
// req/we/addr/wdata stable until it sees host_gnt=1. cpu_stall=1 means
// the CPU access was not performed and must be repeated.
// dbg_owner exposes the grant decision for checkers.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        host_err;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [15:0] conflict_cnt;
  owner_e      dbg_owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata, host_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output conflict_cnt, dbg_owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata, host_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  conflict_cnt, dbg_owner
  );
endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// sat_counter: up-counter that stops at all-ones.
//   clk     : clock
//   rst_n   : asynchronous active-low clear
//   i_inc   : increment request this cycle
//   o_count : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (i_inc && (r_count != {WIDTH{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between a CPU and a host.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (CPU, host and memory signals)
// The CPU normally wins; a host that has waited MAX_WAIT conflict cycles
// wins the next one and stalls the CPU. Host accesses beyond DEPTH words
// are granted but dropped and flagged on host_err the next cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam logic [3:0]  MAX_WAIT_W = 4'(MAX_WAIT);
  localparam logic [29:0] DEPTH_W    = 30'(DEPTH);

  logic [3:0]  r_wait_cnt;
  logic        r_host_rvalid;
  logic [31:0] r_host_rdata;
  logic        r_host_err;

  owner_e      w_owner;
  logic        w_conflict;
  logic        w_host_oor;
  logic        w_host_gnt;
  logic [15:0] w_conflict_cnt;
  logic        w_unused;

  // Byte-lane bits of the host address do not select a word.
  assign w_unused = ^bus.host_addr[1:0];

  assign w_conflict = bus.cpu_req & bus.host_req;
  assign w_host_oor = (bus.host_addr[31:2] >= DEPTH_W);

  always_comb begin
    w_owner = OWN_NONE;
    if (!reset)
      w_owner = OWN_NONE;
    else if (bus.host_req && (!bus.cpu_req || (r_wait_cnt == MAX_WAIT_W)))
      w_owner = OWN_HOST;
    else if (bus.cpu_req)
      w_owner = OWN_CPU;
  end

  assign w_host_gnt = (w_owner == OWN_HOST);

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (w_owner)
      OWN_CPU: begin
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
      OWN_HOST: begin
        // Out-of-range host writes own the port but never write.
        bus.mem_we    = bus.host_we & ~w_host_oor;
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
      end
      default: ;
    endcase
  end

  // The CPU only stalls when it asked and lost to the host.
  assign bus.cpu_stall = bus.cpu_req & w_host_gnt;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.host_gnt  = w_host_gnt;
  assign bus.dbg_owner = w_owner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt    <= '0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
      r_host_err    <= 1'b0;
    end else begin
      if (!bus.host_req || w_host_gnt)
        r_wait_cnt <= '0;
      else if (w_conflict && (r_wait_cnt < MAX_WAIT_W))
        r_wait_cnt <= r_wait_cnt + 4'd1;

      r_host_rvalid <= w_host_gnt & ~bus.host_we & ~w_host_oor;
      r_host_err    <= w_host_gnt & w_host_oor;
      if (w_host_gnt && w_host_oor)
        r_host_rdata <= '0;
      else if (w_host_gnt && !bus.host_we)
        r_host_rdata <= bus.mem_rdata;
    end
  end

  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.host_err    = r_host_err;

  sat_counter #(.WIDTH(16)) u_conflict_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_inc   (w_conflict),
    .o_count (w_conflict_cnt)
  );

  assign bus.conflict_cnt = w_conflict_cnt;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 4, host wait cycles before host wins a conflict; legal range 1..15.
REQ-002 Parameter: DEPTH, default 64, data-memory depth in 32-bit words.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 cpu_req  in  1  CPU data access this cycle (load or store).
REQ-006 cpu_we  in  1  CPU store when 1.
REQ-007 cpu_addr  in  32  CPU byte address.
REQ-008 cpu_wdata  in  32  CPU store data.
REQ-009 cpu_stall  out  1  freeze CPU pipeline; access not performed this cycle.
REQ-010 cpu_rdata  out  32  CPU load data, combinational from mem_rdata.
REQ-011 host_req  in  1  host (loader/readout) access request.
REQ-012 host_we  in  1  host write when 1.
REQ-013 host_addr  in  32  host byte address.
REQ-014 host_wdata  in  32  host write data.
REQ-015 host_gnt  out  1  host access performed this cycle.
REQ-016 host_rvalid  out  1  registered host read data valid.
REQ-017 host_rdata  out  32  registered host read data.
REQ-018 host_err  out  1  registered one-cycle pulse: out-of-range host access.
REQ-019 mem_we  out  1  data-memory write enable.
REQ-020 mem_addr  out  32  data-memory address.
REQ-021 mem_wdata  out  32  data-memory write data.
REQ-022 mem_rdata  in  32  data-memory read data, combinational read.
REQ-023 conflict_cnt  out  16  saturating count of cycles with both requesters active.

Function
REQ-024 At most one requester SHALL drive mem_we/mem_addr/mem_wdata per cycle; idle cycle: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 Only cpu_req high: CPU granted, cpu_stall=0.
REQ-026 Only host_req high: host granted, host_gnt=1, cpu_stall=0.
REQ-027 Both high and wait_cnt < MAX_WAIT: CPU granted, host_gnt=0, wait_cnt increments.
REQ-028 Both high and wait_cnt == MAX_WAIT: host granted, cpu_stall=1, CPU access not performed.
REQ-029 wait_cnt (4-bit) SHALL clear on every host grant and when host_req is low; it never exceeds MAX_WAIT.
REQ-030 Host SHALL hold host_req/we/addr/wdata stable until host_gnt; host_gnt is combinational same-cycle.
REQ-031 Granted host read: host_rdata <= mem_rdata and host_rvalid=1 on the next rising edge; host_rvalid is 0 otherwise.
REQ-032 Host access with host_addr[31:2] >= DEPTH: host_gnt=1, no memory write, host_err=1 next cycle, host_rvalid stays 0, host_rdata=0.
REQ-033 CPU addresses SHALL NOT be range-checked; they pass through unchanged.
REQ-034 conflict_cnt increments on each cycle with cpu_req & host_req, saturating at 16'hFFFF.
REQ-035 cpu_stall SHALL depend only on current requests and wait_cnt; never asserted without cpu_req.

Reset
REQ-036 While reset=0: wait_cnt=0, host_rvalid=0, host_rdata=0, host_err=0, conflict_cnt=0; host_gnt=0, mem_we=0, cpu_stall=0 (forced).
REQ-037 Reset mid-host-read SHALL discard the pending host_rvalid; no response after release.
REQ-038 First grant decision after release SHALL use wait_cnt=0.

Structure
REQ-039 Package dmem_arb_pkg SHALL hold MAX_WAIT/DEPTH defaults and owner enum {OWN_NONE, OWN_CPU, OWN_HOST}.
REQ-040 One sub-module sat_counter (width parameter, increment, async active-low clear) SHALL implement conflict_cnt.

Verification
REQ-041 CPU-only store addr 0x10 data 0xDEADBEEF -> mem_we=1, mem_addr=0x10, cpu_stall=0 same cycle.
REQ-042 Host read addr 0x08, mem_rdata 0x12345678 -> host_gnt=1 cycle N, host_rvalid=1, host_rdata=0x12345678 cycle N+1.
REQ-043 Both requesting continuously, MAX_WAIT=4 -> CPU granted 4 cycles, cycle 5 host_gnt=1 and cpu_stall=1, pattern repeats every 5 cycles.
REQ-044 Host write addr 0x100 (word 64), DEPTH=64 -> host_gnt=1, mem_we=0, host_err=1 next cycle.
REQ-045 reset=0 during cycle after host read grant -> host_rvalid never rises, all registered outputs 0.
REQ-046 Force 70000 conflict cycles -> conflict_cnt holds 16'hFFFF.
